// File: rtl/sm3_pkg.sv
// sm3_pkg: shared SM3 constants, word/state types and rotate helpers.
package sm3_pkg;
    typedef logic [31:0] sm3_word_t;
    typedef sm3_word_t [0:7] sm3_state_t;

    localparam sm3_state_t SM3_IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam sm3_word_t T_LO = 32'h79cc4519;
    localparam sm3_word_t T_HI = 32'h7a879d8a;
    localparam logic [5:0] LAST_RND = 6'd63;

    function automatic sm3_word_t rotl32(input sm3_word_t x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic sm3_word_t p0(input sm3_word_t x);
        return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
    endfunction
endpackage

// File: rtl/sm3_cmprss_round.sv
// sm3_cmprss_round: combinational single SM3 compression round on A..H.
module sm3_cmprss_round
    import sm3_pkg::*;
(
    input  sm3_state_t st,
    input  logic [5:0] j,
    input  sm3_word_t  wj,
    input  sm3_word_t  wjj,
    output sm3_state_t nxt
);
    sm3_word_t a12, ss1, ss2, ff, gg, tt1, tt2;
    logic lo;

    always_comb begin
        lo  = j < 6'd16;
        a12 = rotl32(st[0], 5'd12);
        ss1 = rotl32(a12 + st[4] + rotl32(lo ? T_LO : T_HI, j[4:0]), 5'd7);
        ss2 = ss1 ^ a12;
        ff  = lo ? st[0] ^ st[1] ^ st[2] : (st[0] & st[1]) | (st[0] & st[2]) | (st[1] & st[2]);
        gg  = lo ? st[4] ^ st[5] ^ st[6] : (st[4] & st[5]) | (~st[4] & st[6]);
        tt1 = ff + st[3] + ss2 + wjj;
        tt2 = gg + st[7] + ss1 + wj;
        nxt = {tt1, st[0], rotl32(st[1], 5'd9), st[2], p0(tt2), st[4], rotl32(st[5], 5'd19), st[6]};
    end
endmodule

// File: rtl/sm3_cmprss_core.sv
// sm3_cmprss_core: SM3 compression registers, round counter and chaining fold.
// Define SM3_CMPRSS_PROT_CHK_EN to add the sticky misaligned-last error flag cmprss_err_o.
module sm3_cmprss_core
    import sm3_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  expnd_inpt_wj_i,
    input  logic [31:0]  expnd_inpt_wjj_i,
    input  logic         expnd_inpt_lst_i,
    input  logic         expnd_inpt_vld_i,
    output logic [255:0] cmprss_otpt_res_o,
    output logic         cmprss_otpt_vld_o,
`ifdef SM3_CMPRSS_PROT_CHK_EN
    output logic         cmprss_err_o,
`endif
    output logic         cmprss_busy_o
);
    sm3_state_t st, v, nxt, vnew;
    logic [5:0] cnt;

    sm3_cmprss_round u_round (
        .st (st),
        .j  (cnt),
        .wj (expnd_inpt_wj_i),
        .wjj(expnd_inpt_wjj_i),
        .nxt(nxt)
    );

    assign vnew          = nxt ^ v;
    assign cmprss_busy_o = cnt != 6'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st                <= SM3_IV;
            v                 <= SM3_IV;
            cnt               <= 6'd0;
            cmprss_otpt_res_o <= '0;
            cmprss_otpt_vld_o <= 1'b0;
        end else begin
            cmprss_otpt_vld_o <= 1'b0;
            if (expnd_inpt_vld_i) begin
                cnt <= cnt + 6'd1;
                if (cnt != LAST_RND) begin
                    st <= nxt;
                end else if (expnd_inpt_lst_i) begin
                    // Final block: publish digest and re-arm for the next message.
                    cmprss_otpt_res_o <= vnew;
                    cmprss_otpt_vld_o <= 1'b1;
                    st                <= SM3_IV;
                    v                 <= SM3_IV;
                end else begin
                    st <= vnew;
                    v  <= vnew;
                end
            end
        end
    end

`ifdef SM3_CMPRSS_PROT_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cmprss_err_o <= 1'b0;
        else if (expnd_inpt_vld_i && expnd_inpt_lst_i && cnt != LAST_RND)
            cmprss_err_o <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_sm3_cmprss_core.sv
// tb_sm3_cmprss_core: scoreboard bench driving expanded SM3 words for known-answer messages.
module tb_sm3_cmprss_core;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  wj, wjj;
    logic         lst, vld;
    logic [255:0] res;
    logic         ovld, busy;
`ifdef SM3_CMPRSS_PROT_CHK_EN
    logic         err;
`endif

    localparam logic [255:0] D_ABC  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] D_ABCD = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

    logic [255:0] exp_q[$];
    logic [31:0]  blk[0:15];
    logic [31:0]  wx[0:67];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sm3_cmprss_core dut (
        .clk              (clk),
        .rst              (rst),
        .expnd_inpt_wj_i  (wj),
        .expnd_inpt_wjj_i (wjj),
        .expnd_inpt_lst_i (lst),
        .expnd_inpt_vld_i (vld),
        .cmprss_otpt_res_o(res),
        .cmprss_otpt_vld_o(ovld),
`ifdef SM3_CMPRSS_PROT_CHK_EN
        .cmprss_err_o     (err),
`endif
        .cmprss_busy_o    (busy)
    );

    // Monitor: every output pulse must match the oldest outstanding expected digest.
    always @(negedge clk) begin
        if (!rst && ovld) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_vld: got res=%h, required no output", res);
            end else begin
                logic [255:0] e;
                e = exp_q.pop_front();
                if (res !== e) begin
                    n_fail++;
                    $display("FAIL digest: got %h, required %h", res, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic expand();
        logic [31:0] t;
        for (int i = 0; i < 16; i++) wx[i] = blk[i];
        for (int i = 16; i < 68; i++) begin
            t = wx[i-16] ^ wx[i-9] ^ rl(wx[i-3], 15);
            wx[i] = t ^ rl(t, 15) ^ rl(t, 23) ^ rl(wx[i-13], 7) ^ wx[i-6];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_abcd(input int b);
        for (int i = 0; i < 16; i++) blk[i] = (b == 0) ? 32'h61626364 : 32'h0;
        if (b != 0) begin
            blk[0]  = 32'h80000000;
            blk[15] = 32'h00000200;
        end
    endtask

    // Drives nw words of the current block; stray marks one extra lst word (-1 for none).
    task automatic send_block(input bit last, input int maxgap, input int nw, input int stray,
                              input logic [255:0] dig);
        expand();
        for (int j = 0; j < nw; j++) begin
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) begin
                vld = 1'b0;
                @(posedge clk); #1;
            end
            wj  = wx[j];
            wjj = wx[j] ^ wx[j+4];
            lst = (last && j == 63) || j == stray;
            vld = 1'b1;
            if (last && j == 63) exp_q.push_back(dig);
            @(posedge clk); #1;
            vld = 1'b0;
            lst = 1'b0;
            check($sformatf("busy_w%0d", j), {255'b0, busy}, {255'b0, j != 63});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("missing_digest", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; lst = 1'b0; wj = '0; wjj = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_res", res, 0);
        check("reset_vld", {255'b0, ovld}, 0);
        check("reset_busy", {255'b0, busy}, 0);

        set_abc();
        send_block(1, 0, 64, -1, D_ABC);
        drain();
        repeat (3) @(posedge clk);
        #1 check("res_hold", res, D_ABC);

        set_abcd(0); send_block(0, 0, 64, -1, 0);
        set_abcd(1); send_block(1, 0, 64, -1, D_ABCD);
        drain();

        set_abc();
        send_block(1, 5, 64, -1, D_ABC);
        drain();

        set_abc();   send_block(1, 0, 64, -1, D_ABC);
        set_abcd(0); send_block(0, 0, 64, -1, 0);
        set_abcd(1); send_block(1, 0, 64, -1, D_ABCD);
        drain();

        set_abc();
        send_block(1, 0, 30, -1, 0);
        rst = 1'b1;
        #3;
        check("midrst_busy", {255'b0, busy}, 0);
        check("midrst_res", res, 0);
        @(posedge clk); #1 rst = 1'b0;
        send_block(1, 0, 64, -1, D_ABC);
        drain();

`ifdef SM3_CMPRSS_PROT_CHK_EN
        check("err_clear", {255'b0, err}, 0);
        set_abc();
        send_block(1, 0, 64, 10, D_ABC);
        drain();
        check("err_sticky", {255'b0, err}, 1);
        rst = 1'b1;
        #3 check("err_rst", {255'b0, err}, 0);
        @(posedge clk); #1 rst = 1'b0;
`endif

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
